if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
Instruction-fetch controller for the five-stage pipeline CPU. It owns the PC and the single address port of the 128-word instruction memory. It shares that port between a boot-time program loader and the fetch stage. In RUN it sequences fetch under stall, jump and branch-flush control, and drives the IF/ID pipeline register.

Parameters:
ADDR_W, 7, word-index width of instruction memory (128 words)
RESET_PC, 0, word index of the first fetched instruction on entering RUN

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
start  in  1  BOOT/HALT -> RUN request, sampled on the clock edge
load_en  in  1  loader write strobe (honoured in BOOT only)
load_adr  in  ADDR_W  loader word index
load_data  in  32  loader instruction word
im_adr  out  32  memory word index, zero-extended from ADDR_W
im_we  out  1  memory write enable
im_wdata  out  32  memory write data
im_is  in  32  instruction read from im_adr (combinational)
im_j  in  1  memory's jump flag (opcode 000010) for im_is
stall  in  1  hazard unit: hold IF
br_taken  in  1  resolved taken branch from a later stage: redirect and flush
br_target  in  ADDR_W  branch target word index
if_pc  out  ADDR_W  IF/ID: PC of the held instruction
if_is  out  32  IF/ID: instruction word
if_valid  out  1  IF/ID: instruction is real (0 = bubble)
state  out  2  00 BOOT, 01 RUN, 10 HALT
halted  out  1  1 when state is HALT

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: applies at the next edge, even mid-run or mid-load.
  - state=BOOT, pc=RESET_PC.
  - if_pc=0, if_is=0, if_valid=0, halted=0.
- Port mux (combinational, all states):
  - BOOT: im_adr=load_adr, im_we=load_en, im_wdata=load_data.
  - RUN and HALT: im_adr=pc, im_we=0, im_wdata=0.
- BOOT:
  - Every cycle with load_en=1 writes one word.
  - if_valid stays 0.
  - start=1 -> RUN at the next edge with pc=RESET_PC.
  - A load_en in the same cycle as start is still written.
- RUN: next-state priority, evaluated every cycle.
  1. br_taken: pc<=br_target; if_valid<=0 (flush); if_pc and if_is unchanged. This overrides stall.
  2. stall: pc, if_pc, if_is and if_valid all hold.
  3. Otherwise: if_is<=im_is, if_pc<=pc, if_valid<=1.
     - If im_j=1: pc<=im_is[ADDR_W-1:0]. The jump's low index bits are the target; no delay slot, no bubble.
     - Else: pc<=pc+1, modulo 2^ADDR_W (127 wraps to 0).
  4. If the case-3 fetch captures im_is==32'h0000000C (syscall): the syscall passes to ID with valid=1, and state<=HALT at the same edge. A stalled or flushed syscall does not halt.
- HALT:
  - pc holds; halted=1.
  - if_valid<=0 on the first HALT edge, then stays 0; if_is and if_pc hold.
  - br_taken and stall are ignored.
  - start=1 -> RUN with pc=RESET_PC, halted=0.
- start in RUN is ignored. load_en outside BOOT is ignored (im_we=0).
- Latency: the instruction at pc appears on if_is one cycle after pc presents it.
- Width rules: pc is ADDR_W bits. All target fields are truncated to ADDR_W.

Test Plan:
- Boot load: rst 1 cycle; write 0x20080005@0, 0x20090003@1, 0x0000000C@2; start.
  - im_we=1 only on the 3 load cycles.
  - if_is shows the 3 words on the next 3 cycles, if_pc 0,1,2, if_valid=1.
  - Then halted=1 and if_valid=0.
- Jump: word 3=0x08000010, word 16=0x0000000C; run from 3.
  - if_pc sequence 3,16 with no bubble; then HALT.
- Stall/flush priority: stall for 2 cycles -> if_pc and if_is hold.
  - stall=1 and br_taken=1 with br_target=40 together -> next cycle if_valid=0, pc=40.
  - The following cycle if_pc=40.
- Wrap-around: memory all NOP (0x00000000), RESET_PC=126.
  - if_pc 126,127,0,1.
- Reset mid-run: assert rst while pc=9 in RUN.
  - Next edge: state=BOOT, if_valid=0, if_is=0, im_adr follows load_adr.
- Ignored inputs: load_en=1 during RUN -> im_we stays 0 and memory is unchanged.
  - start during RUN -> pc sequence is unaffected.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, shares the instruction-memory port
// between the boot loader and fetch, and drives the IF/ID register.
module if_fetch_ctrl #(
  parameter int          ADDR_W   = 7,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_adr,
  input  logic [31:0]       load_data,
  output logic [31:0]       im_adr,
  output logic              im_we,
  output logic [31:0]       im_wdata,
  input  logic [31:0]       im_is,
  input  logic              im_j,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_is,
  output logic              if_valid,
  output logic [1:0]        state,
  output logic              halted
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } st_t;

  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
  localparam logic [31:0]       SYSCALL = 32'h0000_000C;

  st_t               st, st_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] if_pc_n;
  logic [31:0]       if_is_n;
  logic              if_valid_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= BOOT;
      pc       <= RST_PC;
      if_pc    <= '0;
      if_is    <= '0;
      if_valid <= 1'b0;
    end else begin
      st       <= st_n;
      pc       <= pc_n;
      if_pc    <= if_pc_n;
      if_is    <= if_is_n;
      if_valid <= if_valid_n;
    end
  end

  always_comb begin
    st_n       = st;
    pc_n       = pc;
    if_pc_n    = if_pc;
    if_is_n    = if_is;
    if_valid_n = if_valid;
    unique case (st)
      BOOT: begin
        if_valid_n = 1'b0;
        if (start) begin
          st_n = RUN;
          pc_n = RST_PC;
        end
      end
      RUN: begin
        // A taken branch wins over stall: the fetch in flight is squashed.
        if (br_taken) begin
          pc_n       = br_target;
          if_valid_n = 1'b0;
        end else if (!stall) begin
          if_is_n    = im_is;
          if_pc_n    = pc;
          if_valid_n = 1'b1;
          pc_n       = im_j ? im_is[ADDR_W-1:0] : pc + 1'b1;
          if (im_is == SYSCALL) st_n = HALT;
        end
      end
      HALT: begin
        if_valid_n = 1'b0;
        if (start) begin
          st_n = RUN;
          pc_n = RST_PC;
        end
      end
      default: st_n = BOOT;
    endcase
  end

  always_comb begin
    if (st == BOOT) begin
      im_adr   = 32'(load_adr);
      im_we    = load_en;
      im_wdata = load_data;
    end else begin
      im_adr   = 32'(pc);
      im_we    = 1'b0;
      im_wdata = '0;
    end
  end

  assign state  = st;
  assign halted = (st == HALT);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: shared instruction memory, two DUTs (RESET_PC 0 and 126),
// a program-level reference model, directed scenarios and a randomized phase.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        load_en = 1'b0;
  logic [6:0]  load_adr = '0;
  logic [31:0] load_data = '0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [6:0]  br_target = '0;

  logic [31:0] im_adr0, im_wdata0, im_is0, if_is0;
  logic        im_we0, im_j0, if_valid0, halted0;
  logic [6:0]  if_pc0;
  logic [1:0]  state0;
  logic [31:0] im_adr1, im_wdata1, im_is1, if_is1;
  logic        im_we1, im_j1, if_valid1, halted1;
  logic [6:0]  if_pc1;
  logic [1:0]  state1;

  logic [31:0] mem [128];
  logic [31:0] img [128];

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.ADDR_W(7), .RESET_PC(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_adr(load_adr),
    .load_data(load_data), .im_adr(im_adr0), .im_we(im_we0), .im_wdata(im_wdata0),
    .im_is(im_is0), .im_j(im_j0), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .if_pc(if_pc0), .if_is(if_is0), .if_valid(if_valid0),
    .state(state0), .halted(halted0));

  if_fetch_ctrl #(.ADDR_W(7), .RESET_PC(126)) u1 (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_adr(load_adr),
    .load_data(load_data), .im_adr(im_adr1), .im_we(im_we1), .im_wdata(im_wdata1),
    .im_is(im_is1), .im_j(im_j1), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .if_pc(if_pc1), .if_is(if_is1), .if_valid(if_valid1),
    .state(state1), .halted(halted1));

  // Memory: combinational read per DUT, writes come from u0's port only.
  assign im_is0 = mem[im_adr0[6:0]];
  assign im_j0  = (im_is0[31:26] == 6'b000010);
  assign im_is1 = mem[im_adr1[6:0]];
  assign im_j1  = (im_is1[31:26] == 6'b000010);

  always @(posedge clk) if (im_we0) mem[im_adr0[6:0]] <= im_wdata0;

  // ---------------- reference model ----------------
  typedef struct {
    int          st;      // 0 boot, 1 run, 2 halt
    int          pc;
    int          if_pc;
    logic [31:0] if_is;
    bit          if_valid;
  } mst_t;

  mst_t m0, m1;

  function automatic mst_t step(mst_t s, int rpc);
    mst_t n = s;
    logic [31:0] w;
    if (rst) begin
      n.st = 0; n.pc = rpc; n.if_pc = 0; n.if_is = 0; n.if_valid = 0;
      return n;
    end
    if (s.st == 0) begin
      if (start) begin n.st = 1; n.pc = rpc; end
    end else if (s.st == 2) begin
      n.if_valid = 0;
      if (start) begin n.st = 1; n.pc = rpc; end
    end else if (br_taken) begin
      n.pc = int'(br_target);
      n.if_valid = 0;
    end else if (!stall) begin
      w = mem[s.pc];
      n.if_is = w; n.if_pc = s.pc; n.if_valid = 1;
      n.pc = (w[31:26] == 6'b000010) ? int'(w % 128) : (s.pc + 1) % 128;
      if (w == 32'h0000000C) n.st = 2;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 <= step(m0, 0);
    m1 <= step(m1, 126);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_dut(input string tag, input mst_t m, input logic [31:0] adr,
                         input logic we, input logic [31:0] wd, input logic [6:0] ipc,
                         input logic [31:0] iis, input logic iv, input logic [1:0] st,
                         input logic h);
    bit boot = (m.st == 0);
    check({tag, ".im_adr"},   64'(adr), boot ? 64'(load_adr) : 64'(m.pc));
    check({tag, ".im_we"},    64'(we),  boot ? 64'(load_en) : 64'd0);
    check({tag, ".im_wdata"}, 64'(wd),  boot ? 64'(load_data) : 64'd0);
    check({tag, ".if_pc"},    64'(ipc), 64'(m.if_pc));
    check({tag, ".if_is"},    64'(iis), 64'(m.if_is));
    check({tag, ".if_valid"}, 64'(iv),  64'(m.if_valid));
    check({tag, ".state"},    64'(st),  64'(m.st));
    check({tag, ".halted"},   64'(h),   64'(m.st == 2));
  endtask

  always @(negedge clk) if (cmp_en) begin
    cmp_dut("u0", m0, im_adr0, im_we0, im_wdata0, if_pc0, if_is0, if_valid0, state0, halted0);
    cmp_dut("u1", m1, im_adr1, im_we1, im_wdata1, if_pc1, if_is1, if_valid1, state1, halted1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_word();
    int r = $urandom_range(0, 99);
    if (r < 8)  return 32'h0000000C;
    if (r < 22) return {6'b000010, 26'($urandom_range(0, 127))};
    return {6'b001000, 26'($urandom)};
  endfunction

  task automatic load_img(input bit check_we);
    for (int i = 0; i < 128; i++) begin
      load_en = 1'b1; load_adr = 7'(i); load_data = img[i];
      #1;
      if (check_we && i < 3) begin
        check("boot.im_we", 64'(im_we0), 64'd1);
        check("boot.im_adr", 64'(im_adr0), 64'(i));
      end
      tick();
    end
    load_en = 1'b0;
  endtask

  initial begin
    // reset
    tick();
    rst = 1'b0;
    check("rst.state", 64'(state0), 64'd0);
    check("rst.if_valid", 64'(if_valid0), 64'd0);
    check("rst.if_is", 64'(if_is0), 64'd0);
    check("rst.if_pc", 64'(if_pc0), 64'd0);
    check("rst.halted", 64'(halted0), 64'd0);
    cmp_en = 1'b1;

    // boot load and first program
    for (int i = 0; i < 128; i++) img[i] = 32'h0;
    img[0] = 32'h20080005; img[1] = 32'h20090003; img[2] = 32'h0000000C;
    img[3] = 32'h08000010; img[16] = 32'h0000000C;
    load_img(1'b1);
    #1 check("boot.idle_we", 64'(im_we0), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("run.state", 64'(state0), 64'd1);
    check("run.im_adr", 64'(im_adr0), 64'd0);
    tick();
    check("f0.is", 64'(if_is0), 64'h20080005);
    check("f0.pc", 64'(if_pc0), 64'd0);
    check("f0.valid", 64'(if_valid0), 64'd1);
    check("wrap.pc126", 64'(if_pc1), 64'd126);
    tick();
    check("f1.is", 64'(if_is0), 64'h20090003);
    check("f1.pc", 64'(if_pc0), 64'd1);
    check("wrap.pc127", 64'(if_pc1), 64'd127);
    tick();
    check("f2.is", 64'(if_is0), 64'h0000000C);
    check("f2.pc", 64'(if_pc0), 64'd2);
    check("f2.valid", 64'(if_valid0), 64'd1);
    check("f2.halted", 64'(halted0), 64'd1);
    check("wrap.pc0", 64'(if_pc1), 64'd0);
    tick();
    check("halt.valid", 64'(if_valid0), 64'd0);
    check("halt.halted", 64'(halted0), 64'd1);
    check("wrap.pc1", 64'(if_pc1), 64'd1);

    // jump: branch into word 3, which jumps to 16 (syscall)
    start = 1'b1; tick(); start = 1'b0;
    br_taken = 1'b1; br_target = 7'd3; tick(); br_taken = 1'b0;
    check("jmp.flush", 64'(if_valid0), 64'd0);
    check("jmp.adr3", 64'(im_adr0), 64'd3);
    tick();
    check("jmp.pc3", 64'(if_pc0), 64'd3);
    check("jmp.is3", 64'(if_is0), 64'h08000010);
    check("jmp.adr16", 64'(im_adr0), 64'd16);
    tick();
    check("jmp.pc16", 64'(if_pc0), 64'd16);
    check("jmp.valid16", 64'(if_valid0), 64'd1);
    check("jmp.halted", 64'(halted0), 64'd1);

    // stall, then stall+branch together
    start = 1'b1; tick(); start = 1'b0;
    br_taken = 1'b1; br_target = 7'd20; tick(); br_taken = 1'b0;
    tick();
    check("stl.pc20", 64'(if_pc0), 64'd20);
    stall = 1'b1; tick(); tick();
    check("stl.hold_pc", 64'(if_pc0), 64'd20);
    check("stl.hold_valid", 64'(if_valid0), 64'd1);
    check("stl.hold_adr", 64'(im_adr0), 64'd21);
    br_taken = 1'b1; br_target = 7'd40; tick();
    check("stl.br_valid", 64'(if_valid0), 64'd0);
    check("stl.br_adr", 64'(im_adr0), 64'd40);
    stall = 1'b0; br_taken = 1'b0; tick();
    check("stl.pc40", 64'(if_pc0), 64'd40);

    // loader and start ignored in RUN
    load_en = 1'b1; load_adr = 7'd50; load_data = 32'hDEADBEEF; start = 1'b1;
    #1 check("ign.we", 64'(im_we0), 64'd0);
    tick();
    load_en = 1'b0; start = 1'b0;
    check("ign.pc41", 64'(if_pc0), 64'd41);
    check("ign.mem50", 64'(mem[50]), 64'd0);

    // reset mid-run at pc 9
    br_taken = 1'b1; br_target = 7'd5; tick(); br_taken = 1'b0;
    tick(); tick(); tick(); tick();
    check("mrst.adr9", 64'(im_adr0), 64'd9);
    rst = 1'b1; load_adr = 7'd77; tick(); rst = 1'b0;
    check("mrst.state", 64'(state0), 64'd0);
    check("mrst.valid", 64'(if_valid0), 64'd0);
    check("mrst.is", 64'(if_is0), 64'd0);
    check("mrst.adr", 64'(im_adr0), 64'd77);

    // randomized phase
    for (int i = 0; i < 128; i++) img[i] = rnd_word();
    load_img(1'b0);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 15) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 9) == 0);
      br_target = 7'($urandom);
      load_en   = ($urandom_range(0, 4) == 0);
      load_adr  = 7'($urandom);
      load_data = rnd_word();
      tick();
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
